fb_arbiter: RTL and testbench

- Shares one single-port frame-buffer RAM (8-bit data, 16-bit address, synchronous 1-cycle read) between two requesters.
  - VGA pixel-fetch path: read requester, latency-sensitive.
  - Camera capture path: write requester, buffered.
- Sits between the capture/VGA logic and the RAM instance, in the 25 MHz pixel-clock domain.
- Reads have priority. Writes are queued in a small FIFO and drain in idle slots, with a starvation guard.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_wr_fifo.sv | 83 ++++++++
 rtl/fb_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fb_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg -- shared definitions for the frame-buffer arbiter.
//
// Contents:
//   FB_ADDR_W / FB_DATA_W : frame-buffer address and pixel widths.
//   gnt_e                 : per-cycle grant decision of the arbiter.
//   wr_entry_t            : one queued camera write (address + pixel).
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_READ,
    GNT_WRITE,
    GNT_FORCE_WR
  } gnt_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// ---------------------------------------------------------------------------
// fb_wr_fifo -- synchronous write-queue FIFO for the frame-buffer arbiter.
//
// Ports:
//   clk_25      in   pixel clock
//   rst         in   synchronous active-high reset (flushes contents)
//   push        in   push request; ignored while full, even if popping
//   push_entry  in   entry to enqueue
//   pop         in   pop request; ignored while empty
//   head        out  oldest entry (combinational read of the head slot)
//   full        out  DEPTH entries stored
//   empty       out  no entries stored
//   level       out  current occupancy, 0..DEPTH
//
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
// ---------------------------------------------------------------------------
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_25,
  input  logic             rst,
  input  logic             push,
  input  wr_entry_t        push_entry,
  input  logic             pop,
  output wr_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  wr_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: every variable assigned in always_comb gets a default on entry, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and level
  // define which slots are meaningful, so a flush only needs those cleared.
  always_ff @(posedge clk_25) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter -- shares one single-port frame-buffer RAM between the VGA
// pixel-fetch reader (priority) and the camera capture writer (queued).
//
// Ports:
//   clk_25, rst            pixel clock, synchronous active-high reset
//   rd_req/rd_addr/rd_gnt  read request (level), address, combinational grant
//   rd_valid/rd_data       registered read return, 3 cycles after grant
//   wr_valid/wr_addr/wr_data/wr_ready  write offer into the queue
//   mem_addr/mem_we/mem_wdata          registered RAM command
//   mem_rdata              RAM read data, one cycle after the address
//   fifo_level             write-queue occupancy
//   starve_evt             forced write pre-empted a pending read this cycle
//   stat_rd/stat_wr/stat_force  grant counters, only with FB_ARB_STATS_EN
//
// Build option: define FB_ARB_STATS_EN to add the 32-bit statistics counters.
// ADDR_W/DATA_W must match FB_ADDR_W/FB_DATA_W, which size wr_entry_t.
// ---------------------------------------------------------------------------
module fb_arbiter
  import fb_pkg::*;
#(
  parameter  int ADDR_W     = FB_ADDR_W,
  parameter  int DATA_W     = FB_DATA_W,
  parameter  int FIFO_DEPTH = 8,
  parameter  int MAX_WAIT   = 15,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LVL_W-1:0]  fifo_level,
`ifdef FB_ARB_STATS_EN
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_force,
`endif
  output logic              starve_evt
);

  localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  // ---------------- write queue ----------------
  wr_entry_t push_entry, head;
  logic      fifo_full, fifo_empty;
  logic      wr_gnt;

  assign push_entry = '{addr: wr_addr, data: wr_data};
  assign wr_ready   = !fifo_full;

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_25     (clk_25),
    .rst        (rst),
    .push       (wr_valid),
    .push_entry (push_entry),
    .pop        (wr_gnt),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  // ---------------- state ----------------
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              rd_p1_q, rd_p1_d;   // read address on the RAM bus
  logic              rd_p2_q, rd_p2_d;   // RAM data on mem_rdata
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
`ifdef FB_ARB_STATS_EN
  logic [31:0]       stat_rd_q, stat_rd_d;
  logic [31:0]       stat_wr_q, stat_wr_d;
  logic [31:0]       stat_force_q, stat_force_d;
`endif

  // ---------------- grant decision ----------------
  gnt_e gnt;

  // The starvation guard outranks the reader; rd_addr never enters here so
  // rd_gnt has no combinational path from the address bus.
  always_comb begin
    gnt = GNT_IDLE;
    if (!fifo_empty && (wait_cnt_q == WAIT_MAX)) gnt = GNT_FORCE_WR;
    else if (rd_req)                             gnt = GNT_READ;
    else if (!fifo_empty)                        gnt = GNT_WRITE;
  end

  assign rd_gnt     = (gnt == GNT_READ);
  assign wr_gnt     = (gnt == GNT_WRITE) || (gnt == GNT_FORCE_WR);
  assign starve_evt = (gnt == GNT_FORCE_WR) && rd_req;

  // ---------------- next state ----------------
  always_comb begin
    // Wait counter: time the queue head has been kept waiting.
    wait_cnt_d = wait_cnt_q;
    if (fifo_empty || wr_gnt)       wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);

    // RAM command: address and write data hold when not refreshed.
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    case (gnt)
      GNT_READ: mem_addr_d = rd_addr;
      GNT_WRITE, GNT_FORCE_WR: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = head.addr;
        mem_wdata_d = head.data;
      end
      default: ;
    endcase

    // Fixed-latency read return: grant -> address -> RAM data -> capture.
    rd_p1_d    = rd_gnt;
    rd_p2_d    = rd_p1_q;
    rd_valid_d = rd_p2_q;
    rd_data_d  = rd_p2_q ? mem_rdata : rd_data_q;

`ifdef FB_ARB_STATS_EN
    stat_rd_d    = stat_rd_q    + (rd_gnt ? 32'd1 : 32'd0);
    stat_wr_d    = stat_wr_q    + (wr_gnt ? 32'd1 : 32'd0);
    stat_force_d = stat_force_q + ((gnt == GNT_FORCE_WR) ? 32'd1 : 32'd0);
`endif
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_25) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rd_p1_q      <= 1'b0;
      rd_p2_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
`ifdef FB_ARB_STATS_EN
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_force_q <= '0;
`endif
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rd_p1_q      <= rd_p1_d;
      rd_p2_q      <= rd_p2_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
`ifdef FB_ARB_STATS_EN
      stat_rd_q    <= stat_rd_d;
      stat_wr_q    <= stat_wr_d;
      stat_force_q <= stat_force_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
`ifdef FB_ARB_STATS_EN
  assign stat_rd    = stat_rd_q;
  assign stat_wr    = stat_wr_q;
  assign stat_force = stat_force_q;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_arbiter -- self-checking bench for fb_arbiter.
// A small synchronous RAM model sits on the mem_* bus; unwritten locations
// read back as addr[7:0]^8'hFF. Define FB_ARB_STATS_EN to also check the
// statistics counters.
// ---------------------------------------------------------------------------
module tb_fb_arbiter;

  logic        clk_25 = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [3:0]  fifo_level;
  logic        starve_evt;
`ifdef FB_ARB_STATS_EN
  logic [31:0] stat_rd, stat_wr, stat_force;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #20 clk_25 = ~clk_25;

  fb_arbiter dut (
    .clk_25     (clk_25),
    .rst        (rst),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fifo_level (fifo_level),
`ifdef FB_ARB_STATS_EN
    .stat_rd    (stat_rd),
    .stat_wr    (stat_wr),
    .stat_force (stat_force),
`endif
    .starve_evt (starve_evt)
  );

  // ---------------- RAM model (tests only touch the low 4K) ----------------
  logic       model_clr;
  logic [7:0] ram [0:4095];

  always @(posedge clk_25) begin
    if (model_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= i[7:0] ^ 8'hFF;
      mem_rdata <= 8'h00;
    end else begin
      mem_rdata <= ram[mem_addr[11:0]];
      if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_25);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_25);
  endtask

  task automatic drive(input logic rr, input logic [15:0] ra, input logic wv,
                       input logic [15:0] wa, input logic [7:0] wd);
    rd_req   = rr;
    rd_addr  = ra;
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rr;   logic [15:0] ra;
    logic        wv;   logic [15:0] wa;  logic [7:0] wd;
    logic        gnt;  logic rdy;  logic rv;  logic [7:0] rdat;
    logic        we;   logic [15:0] ma;  logic [7:0] mwd;
    logic [3:0]  lvl;  logic stv;
  } vec_t;

  function automatic vec_t v(input logic rr, input logic [15:0] ra, input logic wv,
                             input logic [15:0] wa, input logic [7:0] wd,
                             input logic gnt, input logic rdy, input logic rv,
                             input logic [7:0] rdat, input logic we,
                             input logic [15:0] ma, input logic [7:0] mwd,
                             input logic [3:0] lvl, input logic stv);
    vec_t r;
    r = '{rr, ra, wv, wa, wd, gnt, rdy, rv, rdat, we, ma, mwd, lvl, stv};
    return r;
  endfunction

  vec_t tbl [20];

  initial begin
    int n_rd;
    int n_extra;
    int idx;
    bit got_force;

    //          rr  ra       wv  wa       wd     gnt rdy rv rdat   we  ma       mwd    lvl stv
    // single write, then four back-to-back reads of 0..3
    tbl[0]  = v(0, 16'h0000, 1, 16'h0010, 8'hA5, 0, 1, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 0);
    tbl[1]  = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 0, 8'h00, 0, 16'h0000, 8'h00, 1, 0);
    tbl[2]  = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 0, 8'h00, 1, 16'h0010, 8'hA5, 0, 0);
    tbl[3]  = v(1, 16'h0000, 0, 16'h0000, 8'h00, 1, 1, 0, 8'h00, 0, 16'h0010, 8'hA5, 0, 0);
    tbl[4]  = v(1, 16'h0001, 0, 16'h0000, 8'h00, 1, 1, 0, 8'h00, 0, 16'h0000, 8'hA5, 0, 0);
    tbl[5]  = v(1, 16'h0002, 0, 16'h0000, 8'h00, 1, 1, 0, 8'h00, 0, 16'h0001, 8'hA5, 0, 0);
    tbl[6]  = v(1, 16'h0003, 0, 16'h0000, 8'h00, 1, 1, 1, 8'hFF, 0, 16'h0002, 8'hA5, 0, 0);
    tbl[7]  = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 1, 8'hFE, 0, 16'h0003, 8'hA5, 0, 0);
    tbl[8]  = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 1, 8'hFD, 0, 16'h0003, 8'hA5, 0, 0);
    tbl[9]  = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 1, 8'hFC, 0, 16'h0003, 8'hA5, 0, 0);
    // read back the written pixel
    tbl[10] = v(1, 16'h0010, 0, 16'h0000, 8'h00, 1, 1, 0, 8'hFC, 0, 16'h0003, 8'hA5, 0, 0);
    tbl[11] = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 0, 8'hFC, 0, 16'h0010, 8'hA5, 0, 0);
    tbl[12] = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 0, 8'hFC, 0, 16'h0010, 8'hA5, 0, 0);
    tbl[13] = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 1, 8'hA5, 0, 16'h0010, 8'hA5, 0, 0);
    // queued write loses to a read, drains in the following idle slot
    tbl[14] = v(0, 16'h0000, 1, 16'h0020, 8'h5A, 0, 1, 0, 8'hA5, 0, 16'h0010, 8'hA5, 0, 0);
    tbl[15] = v(1, 16'h0004, 0, 16'h0000, 8'h00, 1, 1, 0, 8'hA5, 0, 16'h0010, 8'hA5, 1, 0);
    tbl[16] = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 0, 8'hA5, 0, 16'h0004, 8'hA5, 1, 0);
    tbl[17] = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 0, 8'hA5, 1, 16'h0020, 8'h5A, 0, 0);
    tbl[18] = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 1, 8'hFB, 0, 16'h0020, 8'h5A, 0, 0);
    tbl[19] = v(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 1, 0, 8'hFB, 0, 16'h0020, 8'h5A, 0, 0);

    // ---------------- reset ----------------
    rst = 1'b1;
    model_clr = 1'b1;
    drive(0, 16'h0, 0, 16'h0, 8'h0);
    repeat (3) @(posedge clk_25);
    #1;
    rst = 1'b0;
    model_clr = 1'b0;
    settle();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_starve_evt", starve_evt, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_gnt", rd_gnt, 0);

    // ---------------- table ----------------
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      drive(tbl[i].rr, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      settle();
      check($sformatf("v%0d_rd_gnt", i),     rd_gnt,     tbl[i].gnt);
      check($sformatf("v%0d_wr_ready", i),   wr_ready,   tbl[i].rdy);
      check($sformatf("v%0d_rd_valid", i),   rd_valid,   tbl[i].rv);
      check($sformatf("v%0d_rd_data", i),    rd_data,    tbl[i].rdat);
      check($sformatf("v%0d_mem_we", i),     mem_we,     tbl[i].we);
      check($sformatf("v%0d_mem_addr", i),   mem_addr,   tbl[i].ma);
      check($sformatf("v%0d_mem_wdata", i),  mem_wdata,  tbl[i].mwd);
      check($sformatf("v%0d_fifo_level", i), fifo_level, tbl[i].lvl);
      check($sformatf("v%0d_starve_evt", i), starve_evt, tbl[i].stv);
    end

    // ---------------- starvation guard ----------------
    next_cycle();
    drive(1, 16'h0040, 1, 16'h0100, 8'h11);
    settle();
    check("stv_first_gnt", rd_gnt, 1);
    n_rd = 0;
    got_force = 0;
    for (int k = 1; k <= 40 && !got_force; k++) begin
      next_cycle();
      drive(1, 16'h0040 + 16'(k), 0, 16'h0, 8'h0);
      settle();
      if (rd_gnt) n_rd++;
      else begin
        got_force = 1;
        check("stv_starve_evt", starve_evt, 1);
        check("stv_level_at_force", fifo_level, 1);
      end
    end
    check("stv_read_grants", n_rd, 15);
    check("stv_forced", got_force, 1);
    next_cycle();
    settle();
    check("stv_reads_resume", rd_gnt, 1);
    check("stv_evt_cleared", starve_evt, 0);
    check("stv_mem_we", mem_we, 1);
    check("stv_mem_addr", mem_addr, 16'h0100);
    check("stv_mem_wdata", mem_wdata, 8'h11);
    check("stv_level_empty", fifo_level, 0);
    check("stv_wait_cnt", dut.wait_cnt_q, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive(0, 16'h0, 0, 16'h0, 8'h0);
    end

    // ---------------- FIFO full under continuous reads ----------------
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      drive(1, 16'h0000, 1, 16'h0200 + 16'(i), 8'h30 + 8'(i));
      settle();
      check($sformatf("full_push%0d_ready", i), wr_ready, (i < 8) ? 1 : 0);
      check($sformatf("full_push%0d_level", i), fifo_level, i);
      check($sformatf("full_push%0d_gnt", i), rd_gnt, 1);
    end
    n_extra = 0;
    got_force = 0;
    for (int k = 0; k < 20 && !got_force; k++) begin
      next_cycle();
      drive(1, 16'h0000, 1, 16'h0208, 8'h38);
      settle();
      if (rd_gnt) n_extra++;
      else begin
        got_force = 1;
        check("full_force_ready", wr_ready, 0);
        check("full_force_level", fifo_level, 8);
        check("full_force_evt", starve_evt, 1);
      end
    end
    check("full_stall_reads", n_extra, 7);
    check("full_forced", got_force, 1);
    next_cycle();
    settle();
    check("full_slot_freed", wr_ready, 1);
    check("full_level_after_pop", fifo_level, 7);
    check("full_first_we", mem_we, 1);
    check("full_first_addr", mem_addr, 16'h0200);
    check("full_first_data", mem_wdata, 8'h30);
    next_cycle();
    drive(0, 16'h0, 0, 16'h0, 8'h0);
    settle();
    check("full_level_refilled", fifo_level, 8);
    idx = 1;
    for (int k = 0; k < 20 && idx < 9; k++) begin
      next_cycle();
      settle();
      if (mem_we) begin
        check($sformatf("drain%0d_addr", idx), mem_addr, 16'h0200 + 16'(idx));
        check($sformatf("drain%0d_data", idx), mem_wdata, 8'h30 + 8'(idx));
        idx++;
      end
    end
    check("drain_count", idx, 9);
    next_cycle();
    settle();
    check("drain_level", fifo_level, 0);

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1, 16'h0000, 1, 16'h0300 + 16'(i), 8'h50 + 8'(i));
    end
    next_cycle();
    drive(1, 16'h0005, 0, 16'h0, 8'h0);
    settle();
    check("mrst_gnt", rd_gnt, 1);
    check("mrst_queued", fifo_level, 3);
    next_cycle();
    drive(0, 16'h0, 0, 16'h0, 8'h0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    settle();
`ifdef FB_ARB_STATS_EN
    check("mrst_stat_rd", stat_rd, 0);
`endif
    for (int k = 0; k < 6; k++) begin
      check($sformatf("mrst%0d_rd_valid", k), rd_valid, 0);
      check($sformatf("mrst%0d_level", k), fifo_level, 0);
      check($sformatf("mrst%0d_mem_we", k), mem_we, 0);
      check($sformatf("mrst%0d_wr_ready", k), wr_ready, 1);
      next_cycle();
      settle();
    end

    // ---------------- grant mix for statistics ----------------
    next_cycle();
    drive(1, 16'h0000, 1, 16'h0400, 8'h44);
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      drive(1, 16'h0000, 0, 16'h0, 8'h0);
    end
    settle();
    check("mix_force_gnt", rd_gnt, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive(0, 16'h0, 1, 16'h0410 + 16'(k), 8'h60 + 8'(k));
      settle();
      if (k >= 2) check($sformatf("mix_steady_level%0d", k), fifo_level, 1);
    end
    next_cycle();
    drive(0, 16'h0, 0, 16'h0, 8'h0);
    next_cycle();
    settle();
    check("mix_level_done", fifo_level, 0);
`ifdef FB_ARB_STATS_EN
    check("stat_rd", stat_rd, 16);
    check("stat_wr", stat_wr, 5);
    check("stat_force", stat_force, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
